// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the run/stop/step sequence counter controller:
// FSM states, sequence mode codes and the per-mode seed values.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    localparam logic [1:0] MODE_UP   = 2'b00;
    localparam logic [1:0] MODE_DOWN = 2'b01;
    localparam logic [1:0] MODE_GRAY = 2'b10;
    localparam logic [1:0] MODE_ODD  = 2'b11;

    localparam logic [2:0] SEED_UP   = 3'b000;
    localparam logic [2:0] SEED_DOWN = 3'b111;
    localparam logic [2:0] SEED_GRAY = 3'b000;
    localparam logic [2:0] SEED_ODD  = 3'b001;

    function automatic logic [2:0] seed_of(input logic [1:0] mode);
        case (mode)
            MODE_UP:   seed_of = SEED_UP;
            MODE_DOWN: seed_of = SEED_DOWN;
            MODE_GRAY: seed_of = SEED_GRAY;
            default:   seed_of = SEED_ODD;
        endcase
    endfunction

endpackage

// File: rtl/counter_seq_step.sv
// Combinational next-value table for every counter sequence, plus the flag
// marking the advance from the last sequence state back to the first.
module counter_seq_step
    import counter_ctrl_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [2:0] q,
    output logic [2:0] q_next,
    output logic       wrap
);

    always_comb begin
        q_next = q;
        wrap   = 1'b0;
        case (mode)
            MODE_UP: begin
                q_next = q + 3'd1;
                wrap   = (q == 3'd7);
            end
            MODE_DOWN: begin
                q_next = q - 3'd1;
                wrap   = (q == 3'd0);
            end
            MODE_GRAY: begin
                wrap = (q == 3'b100);
                case (q)
                    3'b000:  q_next = 3'b001;
                    3'b001:  q_next = 3'b011;
                    3'b011:  q_next = 3'b010;
                    3'b010:  q_next = 3'b110;
                    3'b110:  q_next = 3'b111;
                    3'b111:  q_next = 3'b101;
                    3'b101:  q_next = 3'b100;
                    default: q_next = 3'b000;
                endcase
            end
            default: begin
                // 7 + 2 overflows to 1 in three bits, closing the odd loop
                q_next = (q | 3'b001) + 3'd2;
                wrap   = ((q | 3'b001) == 3'd7);
            end
        endcase
    end

endmodule

// File: rtl/counter_run_ctrl.sv
// Run/stop/step controller: loads a mode seed on START, advances the 3-bit
// counter while running or on STEP in pause, and ends after LEN advances.
module counter_run_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int LEN_W = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             STEP,
    input  logic [1:0]       MODE,
    input  logic [LEN_W-1:0] LEN,
    output logic [2:0]       Q,
    output logic             BUSY,
    output logic             DONE,
    output logic             WRAP
);

    state_t             state_q;
    logic [2:0]         q_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [LEN_W-1:0]   len_q;
    logic [1:0]         mode_q;
    logic               busy_q;
    logic               done_q;
    logic               wrap_q;

    logic [2:0]         q_step;
    logic               wrap_step;
    logic               adv;
    logic [LEN_W-1:0]   cnt_inc;
    logic               last_adv;

    counter_seq_step u_seq_step (
        .mode   (mode_q),
        .q      (q_q),
        .q_next (q_step),
        .wrap   (wrap_step)
    );

    // STOP outranks everything; STEP only counts when neither STOP nor START is up
    always_comb begin
        adv      = ((state_q == ST_RUN) && !STOP) ||
                   ((state_q == ST_PAUSE) && !STOP && !START && STEP);
        cnt_inc  = cnt_q + 1'b1;
        last_adv = adv && (len_q != '0) && (cnt_inc == len_q);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            q_q     <= 3'b000;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= MODE_UP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        mode_q  <= MODE;
                        len_q   <= LEN;
                        q_q     <= seed_of(MODE);
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (STOP) begin
                        state_q <= ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    if (STOP) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (START) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase

            if (adv) begin
                q_q    <= q_step;
                wrap_q <= wrap_step;
                cnt_q  <= cnt_inc;
                if (last_adv) begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign Q    = q_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign WRAP = wrap_q;

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed walk through the controller's operating scenarios followed by a
// random phase, all checked each cycle against a sequence-position model.
module tb_counter_run_ctrl;

    logic       CLK = 1'b0;
    logic       RST, START, STOP, STEP;
    logic [1:0] MODE;
    logic [3:0] LEN;
    logic [2:0] Q;
    logic       BUSY, DONE, WRAP;

    int compared = 0;
    int mismatched = 0;

    counter_run_ctrl #(.LEN_W(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .STEP(STEP),
        .MODE(MODE), .LEN(LEN), .Q(Q), .BUSY(BUSY), .DONE(DONE), .WRAP(WRAP)
    );

    always #5 CLK = ~CLK;

    // Reference model: each mode is a list of values walked by position index
    int seq_tab [4][8];
    int seq_len [4];
    bit m_busy, m_paused, m_done, m_wrap;
    int m_pos, m_mode, m_len, m_cnt;
    int exp_q;

    task automatic model_advance();
        m_pos  = (m_pos + 1) % seq_len[m_mode];
        m_wrap = (m_pos == 0);
        exp_q  = seq_tab[m_mode][m_pos];
        m_cnt  = (m_cnt + 1) % 16;
        if (m_len != 0 && m_cnt == m_len) begin
            m_busy   = 0;
            m_paused = 0;
            m_done   = 1;
        end
    endtask

    task automatic model_update(input bit r, st, sp, sx, input int md, input int ln);
        m_done = 0;
        m_wrap = 0;
        if (r) begin
            m_busy = 0; m_paused = 0; exp_q = 0; m_cnt = 0; m_len = 0; m_mode = 0;
        end else if (!m_busy) begin
            if (st) begin
                m_mode = md; m_len = ln; m_pos = 0; m_cnt = 0;
                exp_q = seq_tab[md][0];
                m_busy = 1; m_paused = 0;
            end
        end else if (!m_paused) begin
            if (sp) m_paused = 1;
            else model_advance();
        end else begin
            if (sp) begin
                m_busy = 0; m_paused = 0;
            end else if (st) begin
                m_paused = 0;
            end else if (sx) begin
                model_advance();
            end
        end
    endtask

    task automatic tick(input bit r, st, sp, sx, input int md, input int ln);
        RST = r; START = st; STOP = sp; STEP = sx;
        MODE = 2'(md); LEN = 4'(ln);
        model_update(r, st, sp, sx, md, ln);
        @(posedge CLK);
        #1;
        compared++;
        assert (Q === 3'(exp_q)) else begin
            mismatched++;
            $error("FAIL q: got %0d expected %0d at %0t", Q, exp_q, $time);
        end
        compared++;
        assert (BUSY === m_busy) else begin
            mismatched++;
            $error("FAIL busy: got %b expected %b at %0t", BUSY, m_busy, $time);
        end
        compared++;
        assert (DONE === m_done) else begin
            mismatched++;
            $error("FAIL done: got %b expected %b at %0t", DONE, m_done, $time);
        end
        compared++;
        assert (WRAP === m_wrap) else begin
            mismatched++;
            $error("FAIL wrap: got %b expected %b at %0t", WRAP, m_wrap, $time);
        end
        $display("t=%0t rst=%b start=%b stop=%b step=%b mode=%0d len=%0d -> q=%0d busy=%b done=%b wrap=%b",
                 $time, r, st, sp, sx, md, ln, Q, BUSY, DONE, WRAP);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int gray_vals [8] = '{0, 1, 3, 2, 6, 7, 5, 4};
        for (int i = 0; i < 8; i++) begin
            seq_tab[0][i] = i;
            seq_tab[1][i] = 7 - i;
            seq_tab[2][i] = gray_vals[i];
            seq_tab[3][i] = (i < 4) ? 2 * i + 1 : 0;
        end
        seq_len = '{8, 8, 8, 4};
        m_pos = 0; m_mode = 0; m_len = 0; m_cnt = 0; exp_q = 0;
        m_busy = 0; m_paused = 0; m_done = 0; m_wrap = 0;
        RST = 1; START = 0; STOP = 0; STEP = 0; MODE = 0; LEN = 0;

        // Reset then idle
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        idle(5);

        // Up count, LEN=3
        tick(0, 1, 0, 0, 0, 3);
        idle(5);

        // Gray free-run, nine values, then pause and abort
        tick(0, 1, 0, 0, 2, 0);
        idle(8);
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        idle(2);

        // Down, LEN=5, pause at 6, two steps, resume to completion
        tick(0, 1, 0, 0, 1, 5);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 0);
        tick(0, 0, 0, 1, 0, 0);
        tick(0, 1, 0, 0, 0, 0);
        idle(4);

        // Odd free-run, pause then abort, then restart reloads seed
        tick(0, 1, 0, 0, 3, 0);
        idle(2);
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        idle(2);
        tick(0, 1, 0, 0, 3, 0);
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);

        // Up, LEN=8, reset when Q reaches 5
        tick(0, 1, 0, 0, 0, 8);
        idle(5);
        tick(1, 0, 0, 0, 0, 0);
        idle(2);

        // STOP coinciding with the final advance, then STEP completes the run
        tick(0, 1, 0, 0, 0, 2);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 0, 0);
        idle(2);

        // Random phase
        for (int i = 0; i < 3000; i++) begin
            bit r, st, sp, sx;
            r  = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 5) == 0);
            sp = ($urandom_range(0, 9) == 0);
            sx = ($urandom_range(0, 2) == 0);
            tick(r, st, sp, sx, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/counter_run_ctrl.md
# counter_run_ctrl

Run/stop/step controller for the lab's 3-bit sequence counter. It loads a mode-dependent seed and advances the counter once per clock while running. It supports a pause state with single-stepping, and ends a run after a programmed number of advances. It sits between push-button/switch inputs and the Q2..Q0 counter outputs, and replaces the free-running counter with a sequenced one.

## Interface
- LEN_W, 4: width of the run-length input and the internal advance counter.
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  begin a run from IDLE (reload the seed), or resume from PAUSE (no reload).
- STOP  in  1  in RUN, pause; in PAUSE, abort to IDLE.
- STEP  in  1  in PAUSE, perform exactly one advance.
- MODE  in  2  sequence select, sampled only on START from IDLE: 00 binary up, 01 binary down, 10 Gray up, 11 odd-only.
- LEN  in  LEN_W  advances per run, sampled only on START from IDLE; 0 means free-run.
- Q  out  3  current counter value {Q2,Q1,Q0}; registered.
- BUSY  out  1  high in RUN and PAUSE.
- DONE  out  1  one-cycle pulse when a run of nonzero LEN completes.
- WRAP  out  1  one-cycle pulse coincident with an advance from the last sequence state to the first.

## Operation
- FSM states are IDLE, RUN and PAUSE. The reset state is IDLE.
- Reset values: Q=000, BUSY=0, DONE=0, WRAP=0, advance count=0, latched mode=00, latched length=0.
- Input priority within a cycle is STOP > START > STEP. Inputs not listed for the current state are ignored.
- IDLE + START: latch MODE and LEN, load Q with the seed, clear the advance count, go to RUN.
  - Seeds: up 000, down 111, Gray 000, odd 001.
- RUN: advance Q every cycle.
  - STOP: go to PAUSE with no advance that cycle.
  - START: ignored.
- PAUSE: Q holds.
  - START: return to RUN with no reload; the first advance occurs on the next edge.
  - STEP: one advance; the state stays PAUSE.
  - STOP: go to IDLE with no DONE pulse. Q holds its value.
- Sequences:
  - Up: 0→1→…→7→0.
  - Down: 7→6→…→0→7.
  - Gray: 000,001,011,010,110,111,101,100, then 000.
  - Odd: 1,3,5,7, then 1.
- WRAP fires on the advance from 7→0 (up), 0→7 (down), 100→000 (Gray), or 7→1 (odd).
- Advance count: increments on every advance, from RUN or from STEP.
  - When latched LEN≠0 and an advance makes count==LEN, the next state is IDLE and DONE pulses. This applies whether the advance came from RUN or from STEP.
  - With LEN=0 the count wraps modulo 2^LEN_W and DONE never fires.
- RST mid-run returns all outputs to their reset values on the next edge, with no DONE.

## Timing
- Outputs are registered. Zero combinational paths from inputs to outputs.
- START sampled at edge k:
  - At k: Q=seed and BUSY=1.
  - First advance at edge k+1.
- With LEN=N: the final advance occurs at edge k+N. At the same edge BUSY→0 and DONE=1 for the cycle following k+N.
- STOP and the final advance in the same cycle: STOP wins. No advance, state becomes PAUSE, no DONE.
- WRAP and DONE may assert in the same cycle.
- STEP held high for several cycles in PAUSE gives one advance per cycle.

## Structure
- Shared package counter_ctrl_pkg holds:
  - state enum {IDLE, RUN, PAUSE};
  - mode constants MODE_UP=2'b00, MODE_DOWN=2'b01, MODE_GRAY=2'b10, MODE_ODD=2'b11;
  - seed constants per mode.
- One combinational sub-module, counter_seq_step: inputs (mode, q), outputs (q_next, wrap). It holds all sequence tables. The FSM and the advance counter stay in counter_run_ctrl.

## Test plan
- RST for 2 cycles, then idle for 5 cycles → Q=000, BUSY=0, DONE=0, WRAP=0 throughout.
- START with MODE=00, LEN=3 → Q sequence 0,1,2,3. BUSY falls at the edge that loads 3. DONE is high for exactly 1 cycle. Q then holds at 3.
- START with MODE=10, LEN=0, run 9 cycles → Q=000,001,011,010,110,111,101,100,000. WRAP is high only in the cycle Q=000 after 100.
- START with MODE=01, LEN=5, assert STOP after Q=6, then STEP×2, then START → Q: 7,6 (pause),5,4 (steps),3,2 (run). DONE pulses after Q=2.
- START with MODE=11, LEN=0, STOP, then STOP again → IDLE with Q held at its pause value, no DONE. A subsequent START reloads Q=001.
- START with MODE=00, LEN=8, assert RST at Q=5 → the next edge gives Q=000 and BUSY=0, with no DONE and no WRAP.
